regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Sequences and shares the write port of the 16-bit register bank.
- The bank is an array of 16-bit registers, each with its own w_flag write strobe and a common data input.
- After reset, the block clears every register to zero. It then grants one write per cycle to NUM_REQ requesters (ALU writeback, memory load, stack/PC unit) using round-robin order.
- It drives one-hot w_flag strobes and a shared wr_data bus into the bank.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8)
- NUM_REGS, 16, number of registers in the bank
- ADDR_W, 4, register address width; must satisfy 2**ADDR_W >= NUM_REGS
- DATA_W, 16, register data width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester write request; held high until granted
- req_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  one-hot, one-cycle accept pulse
- w_flag  out  NUM_REGS  one-hot write strobes to the register bank
- wr_data  out  DATA_W  data to the register bank inputs
- init_done  out  1  high once the clear sequence has completed
- addr_err  out  1  one-cycle pulse when a granted address is >= NUM_REGS

Behaviour:
- Reset state (rst_n low, asynchronous):
  - gnt=0, w_flag=0, wr_data=0, init_done=0, addr_err=0.
  - FSM goes to INIT, clear counter=0, round-robin pointer=0 (requester 0 has top priority).
- FSM states are INIT and ARB.
- INIT:
  - One register is cleared per cycle: w_flag = onehot(cnt), wr_data = 0, cnt increments.
  - The first INIT strobe appears in the first clock edge after rst_n rises.
  - After the strobe for index NUM_REGS-1, go to ARB and set init_done=1 on that same edge. The clear takes exactly NUM_REGS cycles.
  - req is ignored during INIT; gnt stays 0.
- ARB arbitration:
  - Evaluated combinationally from the current req.
  - Search order is ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - The first active requester wins.
- ARB registered outputs (1-cycle latency): on the next edge the block drives
  - gnt[win]=1
  - wr_data = req_data[win]
  - w_flag = onehot(req_addr[win])
  - ptr = (win+1) mod NUM_REQ
- If no request is active: gnt=0, w_flag=0, wr_data holds its previous value, ptr unchanged.
- Handshake:
  - The write to the bank occurs on the edge after gnt/w_flag are high. gnt high means the request is consumed.
  - In any cycle where gnt[i]=1, req[i] is masked out of arbitration. The requester may deassert req in that cycle without risk of a double write.
  - A single requester holding req permanently is therefore granted at most every other cycle.
  - Different requesters may be granted on consecutive cycles.
- Address out of range (req_addr >= NUM_REGS):
  - The request is still granted (gnt pulses) and ptr advances.
  - w_flag is all zero, so no register is written.
  - addr_err pulses for one cycle, coincident with gnt.
- Invariants:
  - At most one bit of w_flag and at most one bit of gnt are ever high.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation: outputs clear immediately, and the full INIT sequence reruns after release.

Optional Feature:
- Macro: REG0_HARDWIRE_EN.
- When defined, register 0 is a constant zero register:
  - An ARB-phase request to address 0 is granted (gnt pulses, ptr advances).
  - w_flag[0] stays 0, and addr_err does not pulse.
  - INIT still strobes w_flag[0] once, writing 0.
- When not defined, address 0 is written like any other register.

Test Plan:
- Reset release with no req -> w_flag = 0x0001, 0x0002, ..., 0x8000 on 16 consecutive cycles with wr_data=0; init_done=1 on the 16th; then w_flag=0 and gnt=0.
- After INIT, req=3'b001, addr0=5, data0=0x1234, req dropped on gnt -> next cycle gnt=3'b001, w_flag=0x0020, wr_data=0x1234; exactly one pulse.
- All three req held high continuously with distinct addrs -> gnt sequence 001, 010, 100, 001, ... one per cycle, with no requester granted twice in a row.
- req[1] held high alone -> gnt[1] pulses every other cycle (1,0,1,0).
- Request with addr=4'hF and NUM_REGS=12 -> gnt pulses, addr_err=1, w_flag=0.
- rst_n pulsed low during ARB with gnt high -> gnt, w_flag and init_done drop at once; INIT restarts at index 0.
- With REG0_HARDWIRE_EN defined, request to addr 0 data 0xBEEF -> gnt pulses, w_flag=0, addr_err=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-bank write arbiter: clears every register after reset, then grants one round-robin write per cycle.
// Optional macro REG0_HARDWIRE_EN makes register 0 a constant zero that ARB-phase writes cannot change.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REGS-1:0]         w_flag,
  output logic [DATA_W-1:0]           wr_data,
  output logic                        init_done,
  output logic                        addr_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {INIT, ARB} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REGS-1:0] wFlag_q, wFlag_d;
  logic [DATA_W-1:0]   wrData_q, wrData_d;
  logic                initDone_q, initDone_d;
  logic                addrErr_q, addrErr_d;

  logic [ADDR_W-1:0]   addrArr [NUM_REQ];
  logic [DATA_W-1:0]   dataArr [NUM_REQ];
  logic [NUM_REQ-1:0]  masked;
  logic [PTR_W-1:0]    idx;
  logic [PTR_W-1:0]    win;
  logic                found;
  logic [ADDR_W-1:0]   winAddr;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addrArr[i] = req_addr[i*ADDR_W +: ADDR_W];
      dataArr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // A requester granted this cycle is masked so a late-dropped req cannot be written twice.
  always_comb begin
    masked = req & ~gnt_q;
    found  = 1'b0;
    win    = '0;
    idx    = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && masked[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
    end
  end

  assign winAddr = addrArr[win];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    wFlag_d    = '0;
    wrData_d   = wrData_q;
    initDone_d = initDone_q;
    addrErr_d  = 1'b0;
    case (state_q)
      INIT: begin
        wFlag_d  = {{(NUM_REGS-1){1'b0}}, 1'b1} << cnt_q;
        wrData_d = '0;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          cnt_d      = '0;
          state_d    = ARB;
          initDone_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ARB: begin
        if (found) begin
          gnt_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
          wrData_d = dataArr[win];
          ptr_d    = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
          if ({1'b0, winAddr} >= (ADDR_W+1)'(NUM_REGS)) begin
            addrErr_d = 1'b1;
          end else begin
            wFlag_d = {{(NUM_REGS-1){1'b0}}, 1'b1} << winAddr;
`ifdef REG0_HARDWIRE_EN
            if (winAddr == '0) wFlag_d = '0;
`endif
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      wFlag_q    <= '0;
      wrData_q   <= '0;
      initDone_q <= 1'b0;
      addrErr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      wFlag_q    <= wFlag_d;
      wrData_q   <= wrData_d;
      initDone_q <= initDone_d;
      addrErr_q  <= addrErr_d;
    end
  end

  assign gnt       = gnt_q;
  assign w_flag    = wFlag_q;
  assign wr_data   = wrData_q;
  assign init_done = initDone_q;
  assign addr_err  = addrErr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a 16-register and a 12-register instance share the same stimulus.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [11:0] req_addr;
  logic [47:0] req_data;

  logic [2:0]  gnt, gnt12;
  logic [15:0] w_flag;
  logic [11:0] w_flag12;
  logic [15:0] wr_data, wr_data12;
  logic        init_done, init_done12;
  logic        addr_err, addr_err12;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.NUM_REQ(3), .NUM_REGS(16), .ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .w_flag(w_flag), .wr_data(wr_data), .init_done(init_done), .addr_err(addr_err)
  );

  regfile_write_arbiter #(.NUM_REQ(3), .NUM_REGS(12), .ADDR_W(4), .DATA_W(16)) dut12 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt12), .w_flag(w_flag12), .wr_data(wr_data12), .init_done(init_done12),
    .addr_err(addr_err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [11:0] a, input logic [47:0] d);
    req      = r;
    req_addr = a;
    req_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] reg0Flag;
`ifdef REG0_HARDWIRE_EN
    reg0Flag = 16'h0000;
`else
    reg0Flag = 16'h0001;
`endif
    rst_n = 1'b1;
    applyStimulus(3'b010, 12'h000, 48'h0);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset gnt", gnt, 0);
    checkOutput("reset w_flag", w_flag, 0);
    checkOutput("reset wr_data", wr_data, 0);
    checkOutput("reset init_done", init_done, 0);
    checkOutput("reset addr_err", addr_err, 0);
    #9 rst_n = 1'b1;

    // Clear sequence: req is held high but must be ignored until init completes.
    for (int i = 0; i < 16; i++) begin
      tick();
      checkOutput($sformatf("init w_flag %0d", i), w_flag, 32'h1 << i);
      checkOutput($sformatf("init wr_data %0d", i), wr_data, 0);
      checkOutput($sformatf("init gnt %0d", i), gnt, 0);
      checkOutput($sformatf("init done %0d", i), init_done, (i == 15) ? 1 : 0);
      if (i == 11) checkOutput("init12 done", init_done12, 1);
      if (i == 14) applyStimulus(3'b000, 12'h000, 48'h0);
    end
    tick();
    checkOutput("post-init w_flag", w_flag, 0);
    checkOutput("post-init gnt", gnt, 0);
    checkOutput("post-init done", init_done, 1);

    // Single write, request dropped in the grant cycle.
    applyStimulus(3'b001, 12'h005, 48'h0000_0000_1234);
    tick();
    checkOutput("single gnt", gnt, 3'b001);
    checkOutput("single w_flag", w_flag, 16'h0020);
    checkOutput("single wr_data", wr_data, 16'h1234);
    checkOutput("single addr_err", addr_err, 0);
    applyStimulus(3'b000, 12'h005, 48'h0000_0000_1234);
    tick();
    checkOutput("single pulse gnt", gnt, 0);
    checkOutput("single pulse w_flag", w_flag, 0);
    checkOutput("single hold wr_data", wr_data, 16'h1234);

    // All three held: pointer sits at 1 after the grant to requester 0.
    applyStimulus(3'b111, {4'd3, 4'd2, 4'd1}, {16'hCCCC, 16'hBBBB, 16'hAAAA});
    tick();
    checkOutput("rr1 gnt", gnt, 3'b010);
    checkOutput("rr1 w_flag", w_flag, 16'h0004);
    checkOutput("rr1 wr_data", wr_data, 16'hBBBB);
    tick();
    checkOutput("rr2 gnt", gnt, 3'b100);
    checkOutput("rr2 w_flag", w_flag, 16'h0008);
    checkOutput("rr2 wr_data", wr_data, 16'hCCCC);
    tick();
    checkOutput("rr3 gnt", gnt, 3'b001);
    checkOutput("rr3 w_flag", w_flag, 16'h0002);
    checkOutput("rr3 wr_data", wr_data, 16'hAAAA);
    tick();
    checkOutput("rr4 gnt", gnt, 3'b010);
    checkOutput("rr4 w_flag", w_flag, 16'h0004);
    applyStimulus(3'b000, 12'h000, 48'h0);
    tick();
    checkOutput("rr idle gnt", gnt, 0);

    // Lone requester held high is granted every other cycle.
    applyStimulus(3'b010, {4'd0, 4'd9, 4'd0}, {16'h0, 16'h5A5A, 16'h0});
    tick();
    checkOutput("hold1 gnt", gnt, 3'b010);
    checkOutput("hold1 w_flag", w_flag, 16'h0200);
    tick();
    checkOutput("hold2 gnt", gnt, 0);
    checkOutput("hold2 w_flag", w_flag, 0);
    tick();
    checkOutput("hold3 gnt", gnt, 3'b010);
    tick();
    checkOutput("hold4 gnt", gnt, 0);
    applyStimulus(3'b000, 12'h000, 48'h0);
    tick();

    // Address 0xF: valid for 16 registers, out of range for 12.
    applyStimulus(3'b001, 12'h00F, 48'h0000_0000_5555);
    tick();
    checkOutput("addrF gnt", gnt, 3'b001);
    checkOutput("addrF w_flag", w_flag, 16'h8000);
    checkOutput("addrF addr_err", addr_err, 0);
    checkOutput("oor gnt", gnt12, 3'b001);
    checkOutput("oor addr_err", addr_err12, 1);
    checkOutput("oor w_flag", w_flag12, 0);
    checkOutput("oor wr_data", wr_data12, 16'h5555);
    applyStimulus(3'b000, 12'h00F, 48'h0);
    tick();
    checkOutput("oor pulse addr_err", addr_err12, 0);
    checkOutput("oor pulse gnt", gnt12, 0);

    // Write to register 0.
    applyStimulus(3'b001, 12'h000, 48'h0000_0000_BEEF);
    tick();
    checkOutput("reg0 gnt", gnt, 3'b001);
    checkOutput("reg0 w_flag", w_flag, reg0Flag);
    checkOutput("reg0 addr_err", addr_err, 0);
    checkOutput("reg0 wr_data", wr_data, 16'hBEEF);
    applyStimulus(3'b000, 12'h000, 48'h0);
    tick();

    // Reset while a grant is on the outputs.
    applyStimulus(3'b100, {4'd7, 4'd0, 4'd0}, {16'h7777, 16'h0, 16'h0});
    tick();
    checkOutput("pre-reset gnt", gnt, 3'b100);
    checkOutput("pre-reset w_flag", w_flag, 16'h0080);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset gnt", gnt, 0);
    checkOutput("midreset w_flag", w_flag, 0);
    checkOutput("midreset init_done", init_done, 0);
    checkOutput("midreset wr_data", wr_data, 0);
    applyStimulus(3'b000, 12'h000, 48'h0);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("reinit w_flag 0", w_flag, 16'h0001);
    checkOutput("reinit done 0", init_done, 0);
    checkOutput("reinit gnt 0", gnt, 0);
    tick();
    checkOutput("reinit w_flag 1", w_flag, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
